game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Top-level game-flow controller, directly upstream of the player-position block.
- Drives `game_state` and the thrust signal `on` into that block, which resets the player to y=419 whenever `game_state` != PLAY.
- Consumes the player button and the collision flag, and keeps a 4-digit BCD run score plus a best score for the HUD renderer.

Parameters:
SCORE_DIV  4  frame ticks per score point (>=1)
OVER_FRAMES  120  frame ticks of input lockout after death (>=1)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high; clock clk
btn  input  1  player button, already synchronized, active-high level
frame_tick  input  1  one-cycle pulse per video frame
hit  input  1  collision level from collision checker, valid in PLAY
on  output  1  thrust request to player-position block
game_state  output  2  00 TITLE, 01 PLAY, 10 OVER (11 unused, never driven)
score  output  16  current run score, 4 BCD digits, [15:12] most significant
high_score  output  16  best score, 4 BCD digits

Behaviour:
- Reset values: game_state=00, on=0, score=0000, high_score=0000, all internal counters 0, btn_q=0.
- Reset is honoured in any state, including mid-PLAY; it returns to TITLE next cycle and also clears high_score.
- Edge detect: btn_q is btn registered every cycle; btn_rise = btn & ~btn_q.
- on = btn_q when game_state==PLAY, else 0. This is registered, one-cycle latency from btn.

TITLE (00):
- btn_rise -> PLAY next cycle.
- On that same transition: score <= 0, frame_cnt <= 0.

PLAY (01):
- Each frame_tick increments frame_cnt.
- When frame_cnt==SCORE_DIV-1 and frame_tick: frame_cnt <= 0 and score increments in BCD (0009 -> 0010, 0099 -> 0100).
- Score saturates at 9999 (no wrap).
- hit==1 in any cycle -> OVER next cycle. The score is NOT incremented in that cycle, even if frame_tick coincides.
- On the transition: lock_cnt <= 0.

OVER (10):
- score holds.
- First cycle in OVER: if score > high_score, high_score <= score (compare as 16-bit unsigned; valid for BCD).
- lock_cnt increments on frame_tick, saturating at OVER_FRAMES.
- btn_rise with lock_cnt==OVER_FRAMES -> TITLE next cycle; btn_rise before that is ignored.
- A button held through the lockout does not restart; a fresh rise is required.

General rules:
- hit is ignored outside PLAY.
- frame_tick is ignored in TITLE.
- Counter widths: $clog2(SCORE_DIV+1) and $clog2(OVER_FRAMES+1).

Optional Feature:
HISCORE_EN
- Defined: high_score register and comparison are present, as described above.
- Undefined: no high_score register; the high_score port is tied to 16'h0000; all other behaviour is identical.

Decomposition:
- Package game_pkg holds:
  - game_state_t, a 2-bit enum TITLE=2'b00, PLAY=2'b01, OVER=2'b10, shared with the player-position block and renderer;
  - localparam BCD_MAX=16'h9999.
- One sub-module, bcd_counter4:
  - inputs clk, reset, clr, inc;
  - output value[15:0];
  - per-digit carry, saturating at 9999, clr has priority over inc.

Test Plan:
1. Reset, then btn 0->1 in TITLE -> game_state=01 one cycle after rise, score=0000, on=1 on the following cycle while btn held.
2. PLAY with SCORE_DIV=4, 40 frame_ticks, hit=0 -> score=0010; continue to 396 ticks -> score=0099, next 4 ticks -> 0100.
3. hit=1 asserted in the same cycle as the 4th frame_tick -> game_state=10 next cycle, score unchanged (e.g. 0007 stays 0007), on=0.
4. OVER with OVER_FRAMES=120: btn_rise after 50 ticks -> stays 10; btn_rise after 120 ticks -> game_state=00.
5. Two runs scoring 0042 then 0017 -> high_score=0042 after both. With HISCORE_EN undefined -> high_score=0000 throughout.
6. Preload score near max (force 9998), 8 scoring ticks -> score=9999 and holds. reset asserted mid-PLAY -> game_state=00, score=0000, high_score=0000 next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow types: the state encoding seen by the player-position
// block and the HUD renderer, plus the BCD score ceiling.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'b00,
        PLAY  = 2'b01,
        OVER  = 2'b10
    } game_state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// Four-digit BCD counter with per-digit carry, saturating at 9999.
// clr has priority over inc.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_inc;
    logic        carry;

    // Ripple a +1 through the digits; a digit at 9 wraps to 0 and passes carry on
    always_comb begin
        value_inc = value;
        carry     = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    value_inc[4*i +: 4] = 4'd0;
                end else begin
                    value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Score register: clear wins, increments stop at the BCD ceiling
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (inc && (value != BCD_MAX)) begin
            value <= value_inc;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: TITLE -> PLAY -> OVER -> TITLE, thrust output,
// BCD run score and (with HISCORE_EN defined) a best-score register.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SCORE_DIV   = 4,
    parameter int unsigned OVER_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        frame_tick,
    input  logic        hit,
    output logic        on,
    output logic [1:0]  game_state,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    localparam int unsigned FW = $clog2(SCORE_DIV + 1);
    localparam int unsigned LW = $clog2(OVER_FRAMES + 1);
    localparam logic [FW-1:0] DIV_LAST = FW'(SCORE_DIV - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(OVER_FRAMES);

    game_state_t   state;
    logic          btn_q;
    logic          btn_rise;
    logic [FW-1:0] frame_cnt;
    logic [LW-1:0] lock_cnt;
    logic          score_clr;
    logic          score_inc;

    assign game_state = state;

    // Button edge detect and score-counter controls; a hit cycle never scores
    always_comb begin
        btn_rise  = btn & ~btn_q;
        score_clr = (state == TITLE) && btn_rise;
        score_inc = (state == PLAY) && !hit && frame_tick && (frame_cnt == DIV_LAST);
    end

    // State machine, frame/lockout counters and thrust output.
    // on is loaded with btn alongside each state update, so it always
    // equals btn_q gated by the state actually being shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TITLE;
            btn_q     <= 1'b0;
            on        <= 1'b0;
            frame_cnt <= '0;
            lock_cnt  <= '0;
        end else begin
            btn_q <= btn;
            case (state)
                TITLE: begin
                    if (btn_rise) begin
                        state     <= PLAY;
                        frame_cnt <= '0;
                        on        <= btn;
                    end else begin
                        on <= 1'b0;
                    end
                end
                PLAY: begin
                    if (hit) begin
                        state    <= OVER;
                        lock_cnt <= '0;
                        on       <= 1'b0;
                    end else begin
                        on <= btn;
                        if (frame_tick) begin
                            if (frame_cnt == DIV_LAST) frame_cnt <= '0;
                            else                       frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                OVER: begin
                    on <= 1'b0;
                    if (frame_tick && (lock_cnt != LOCK_MAX)) begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                    if (btn_rise && (lock_cnt == LOCK_MAX)) begin
                        state <= TITLE;
                    end
                end
                default: begin
                    state <= TITLE;
                    on    <= 1'b0;
                end
            endcase
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .value (score)
    );

`ifdef HISCORE_EN
    logic        over_first;
    logic [15:0] best;

    // Latch the run score into the best score during the first OVER cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            over_first <= 1'b0;
            best       <= '0;
        end else begin
            over_first <= (state == PLAY) && hit;
            if (over_first && (score > best)) begin
                best <= score;
            end
        end
    end

    assign high_score = best;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (SCORE_DIV=4, OVER_FRAMES=120).
module tb_game_ctrl;

    logic        clk;
    logic        reset;
    logic        btn;
    logic        frame_tick;
    logic        hit;
    logic        on;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [15:0] high_score;

    int unsigned tests;
    int unsigned fails;

`ifdef HISCORE_EN
    localparam logic [15:0] HS_AFTER_RUNS = 16'h0042;
`else
    localparam logic [15:0] HS_AFTER_RUNS = 16'h0000;
`endif

    game_ctrl #(.SCORE_DIV(4), .OVER_FRAMES(120)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .frame_tick (frame_tick),
        .hit        (hit),
        .on         (on),
        .game_state (game_state),
        .score      (score),
        .high_score (high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int unsigned n);
        frame_tick = 1'b1;
        repeat (n) tick();
        frame_tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; btn = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", 16'(game_state), 16'h0000);
        chk("rst_on",    16'(on),         16'h0000);
        chk("rst_score", score,           16'h0000);
        chk("rst_hs",    high_score,      16'h0000);

        // frame ticks in TITLE must not affect anything
        frames(7);
        chk("title_state", 16'(game_state), 16'h0000);

        // start run A
        btn = 1'b1; tick();
        chk("start_state", 16'(game_state), 16'h0001);
        chk("start_score", score,           16'h0000);
        tick();
        chk("start_on",    16'(on),         16'h0001);

        frames(40);
        chk("score_10",  score, 16'h0010);
        frames(356);
        chk("score_99",  score, 16'h0099);
        frames(4);
        chk("score_100", score, 16'h0100);

        // reset mid-PLAY
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_state", 16'(game_state), 16'h0000);
        chk("midrst_score", score,           16'h0000);
        chk("midrst_on",    16'(on),         16'h0000);

        // run B: reach 0042, three more ticks, hit on the scoring tick
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        chk("runB_state", 16'(game_state), 16'h0001);
        frames(168);
        chk("runB_42", score, 16'h0042);
        frames(3);
        chk("runB_42b", score, 16'h0042);
        frame_tick = 1'b1; hit = 1'b1; tick();
        frame_tick = 1'b0; hit = 1'b0;
        chk("hit_state", 16'(game_state), 16'h0002);
        chk("hit_score", score,           16'h0042);
        chk("hit_on",    16'(on),         16'h0000);
        tick();
        chk("runB_hs", high_score, HS_AFTER_RUNS);

        // lockout: early rise ignored
        btn = 1'b0;
        frames(50);
        btn = 1'b1; tick();
        chk("early_rise", 16'(game_state), 16'h0002);
        btn = 1'b0; tick();
        // held through the rest of the lockout (rise at lock 51 ignored)
        btn = 1'b1;
        frames(80);
        tick();
        chk("held_btn",   16'(game_state), 16'h0002);
        chk("over_score", score,           16'h0042);
        chk("over_on",    16'(on),         16'h0000);
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        chk("unlock_state", 16'(game_state), 16'h0000);
        chk("title_score",  score,           16'h0042);

        // run C: 0017, must not replace the best score
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        chk("runC_state", 16'(game_state), 16'h0001);
        chk("runC_clr",   score,           16'h0000);
        frames(68);
        chk("runC_17", score, 16'h0017);
        hit = 1'b1; tick(); hit = 1'b0;
        chk("runC_over", 16'(game_state), 16'h0002);
        tick();
        chk("runC_hs",    high_score, HS_AFTER_RUNS);
        chk("runC_score", score,      16'h0017);

        // saturation run
        btn = 1'b0;
        frames(120);
        btn = 1'b1; tick();
        chk("exitC_state", 16'(game_state), 16'h0000);
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        chk("runD_state", 16'(game_state), 16'h0001);
        frames(39992);
        chk("score_9998", score, 16'h9998);
        frames(4);
        chk("score_9999", score, 16'h9999);
        frames(8);
        chk("score_sat",  score, 16'h9999);
        chk("runD_play",  16'(game_state), 16'h0001);

        reset = 1'b1; tick(); reset = 1'b0;
        chk("endrst_state", 16'(game_state), 16'h0000);
        chk("endrst_score", score,           16'h0000);
        chk("endrst_hs",    high_score,      16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
